uds_out_serializer: RTL and testbench

//  Downstream of the UDS up/downsample engine. Captures each wide result frame (odata/odata_valid)

---
 rtl/uds_pkg.sv | 25 ++
 rtl/uds_out_serializer_if.sv | 14 +
 rtl/uds_frame_pingpong.sv | 58 +++++
 rtl/uds_out_serializer.sv | 98 +++++++++
 tb/tb_uds_out_serializer.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/uds_pkg.sv
// Shared constants, row-count helpers and drain-state encoding for the UDS output serializer.
package uds_pkg;
  localparam int UDS_A     = 64;
  localparam int UDS_DW    = 32;
  localparam int UDS_ROW_W = 8;

  // index of the function_mode bit that selects upsample
  localparam int MODE_UPSAMPLE = 1;

  function automatic int up_rows(input int a);
    return 2 * (a / 8) - 2;
  endfunction

  function automatic int dn_rows(input int a);
    return a / 16;
  endfunction

  function automatic int frame_w(input int a, input int dw);
    return 2 * (a - 8) * dw;
  endfunction

  localparam int FRAME_W = frame_w(UDS_A, UDS_DW);

  typedef enum logic [0:0] {IDLE = 1'b0, STREAM = 1'b1} drain_state_e;
endpackage

// File: rtl/uds_out_serializer_if.sv
// Row stream from the serializer to its consumer (valid/ready plus framing).
interface uds_out_serializer_if import uds_pkg::*; #(
  parameter int RW = UDS_ROW_W * UDS_DW
) ();
  logic [RW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    out_row;
  logic          out_sop;
  logic          out_eop;

  modport master (output out_data, out_valid, out_row, out_sop, out_eop, input out_ready);
  modport slave  (input out_data, out_valid, out_row, out_sop, out_eop, output out_ready);
endinterface

// File: rtl/uds_frame_pingpong.sv
// Two-entry frame buffer: captures into wr_ptr, drains from rd_ptr, flags frames that find no room.
module uds_frame_pingpong import uds_pkg::*; #(
  parameter int FW = FRAME_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_valid,
  input  logic [FW-1:0] wr_data,
  input  logic          wr_mode,
  input  logic          pop,
  output logic [FW-1:0] rd_data,
  output logic          rd_mode,
  output logic          rd_occ,
  output logic          other_occ_nxt,
  output logic          busy,
  output logic          drop
);
  logic [1:0][FW-1:0] bufs;
  logic [1:0]         mode;
  logic [1:0]         occ;
  logic               wr_ptr, rd_ptr;
  logic               capture;

  // occ is the pre-edge value, so a buffer freed by pop this cycle still reads as full
  assign capture = wr_valid && !occ[wr_ptr];
  assign drop    = wr_valid &&  occ[wr_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (capture) begin
        occ[wr_ptr] <= 1'b1;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        occ[rd_ptr] <= 1'b0;
        rd_ptr      <= ~rd_ptr;
      end
    end
  end

  // payload is only observed behind occ, so it needs no reset
  always_ff @(posedge clk) begin
    if (capture) begin
      bufs[wr_ptr] <= wr_data;
      mode[wr_ptr] <= wr_mode;
    end
  end

  assign rd_data       = bufs[rd_ptr];
  assign rd_mode       = mode[rd_ptr];
  assign rd_occ        = occ[rd_ptr];
  assign other_occ_nxt = occ[~rd_ptr] || (capture && (wr_ptr != rd_ptr));
  assign busy          = |occ;
endmodule

// File: rtl/uds_out_serializer.sv
// Buffers UDS result frames in a ping-pong pair and streams them out as 8-word rows with sop/eop.
module uds_out_serializer import uds_pkg::*; #(
  parameter int A     = UDS_A,
  parameter int DW    = UDS_DW,
  parameter int ROW_W = UDS_ROW_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              function_mode,
  input  logic [2*(A-8)*DW-1:0]   in_data,
  input  logic                    in_valid,
  uds_out_serializer_if.master    out,
  output logic                    busy,
  output logic                    overflow,
  output logic [7:0]              frames_dropped
);
  localparam int FW  = frame_w(A, DW);
  localparam int RW  = ROW_W * DW;
  localparam int UPR = up_rows(A);
  localparam int DNR = dn_rows(A);

  localparam logic [0:0] S_IDLE   = 1'(IDLE);
  localparam logic [0:0] S_STREAM = 1'(STREAM);

  logic [0:0]              state;
  logic [3:0]              row_idx, last;
  logic                    valid, accept, pop, drop;
  logic [FW-1:0]           rd_data;
  logic                    rd_mode, rd_occ, other_occ_nxt;
  logic [UPR-1:0][RW-1:0]  rows;
  logic [RW-1:0]           row_sel;
  logic                    unused_mode;

  assign unused_mode = function_mode[0];

  uds_frame_pingpong #(.FW(FW)) u_pp (
    .clk           (clk),
    .rst           (rst),
    .wr_valid      (in_valid),
    .wr_data       (in_data),
    .wr_mode       (function_mode[MODE_UPSAMPLE]),
    .pop           (pop),
    .rd_data       (rd_data),
    .rd_mode       (rd_mode),
    .rd_occ        (rd_occ),
    .other_occ_nxt (other_occ_nxt),
    .busy          (busy),
    .drop          (drop)
  );

  assign last   = rd_mode ? 4'(UPR - 1) : 4'(DNR - 1);
  assign valid  = (state == S_STREAM);
  assign accept = valid && out.out_ready;
  assign pop    = accept && (row_idx == last);

  assign rows = rd_data;
  always_comb begin
    row_sel = '0;
    for (int r = 0; r < UPR; r++)
      if (row_idx == 4'(r)) row_sel = rows[r];
  end

  assign out.out_valid = valid;
  assign out.out_data  = valid ? row_sel : '0;
  assign out.out_row   = valid ? row_idx : 4'd0;
  assign out.out_sop   = valid && (row_idx == 4'd0);
  assign out.out_eop   = valid && (row_idx == last);

  // stay in STREAM across frames when the other buffer is (or is becoming) full: no bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      row_idx <= 4'd0;
    end else if (state == S_IDLE) begin
      if (rd_occ) begin
        state   <= S_STREAM;
        row_idx <= 4'd0;
      end
    end else if (accept) begin
      if (row_idx == last) begin
        row_idx <= 4'd0;
        if (!other_occ_nxt) state <= S_IDLE;
      end else begin
        row_idx <= row_idx + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow       <= 1'b0;
      frames_dropped <= 8'd0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (frames_dropped != 8'hFF) frames_dropped <= frames_dropped + 8'd1;
    end
  end
endmodule

// File: tb/tb_uds_out_serializer.sv
// Directed bench for uds_out_serializer: latency, framing, backpressure, overflow, saturation, reset.
module tb_uds_out_serializer;
  localparam int FW = 3584;
  localparam int RW = 256;

  typedef struct {
    logic [RW-1:0] d;
    logic [3:0]    row;
    logic          sop;
    logic          eop;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    function_mode;
  logic [FW-1:0] in_data;
  logic          in_valid;
  logic          busy, overflow;
  logic [7:0]    frames_dropped;

  int n_chk  = 0;
  int n_pass = 0;
  beat_t q[$];

  uds_out_serializer_if oif ();

  uds_out_serializer dut (
    .clk            (clk),
    .rst            (rst),
    .function_mode  (function_mode),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .out            (oif),
    .busy           (busy),
    .overflow       (overflow),
    .frames_dropped (frames_dropped)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (oif.out_valid && oif.out_ready)
      q.push_back('{oif.out_data, oif.out_row, oif.out_sop, oif.out_eop});

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [RW-1:0] exp_row(input logic [7:0] seed, input int r);
    logic [RW-1:0] v;
    for (int w = 0; w < 8; w++) v[w*32 +: 32] = {seed, 8'(r), 8'(w), 8'hC3};
    return v;
  endfunction

  function automatic logic [FW-1:0] make_frame(input logic [7:0] seed);
    logic [FW-1:0] f;
    for (int r = 0; r < 14; r++) f[r*RW +: RW] = exp_row(seed, r);
    return f;
  endfunction

  // {valid,row,sop,eop} packed for compact comparison
  function automatic logic [RW-1:0] meta(input logic v, input logic [3:0] r, input logic s, input logic e);
    return RW'({v, r, s, e});
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode changes right after capture; the stored frame must keep the captured mode
  task automatic send(input logic [7:0] seed, input logic up);
    in_data       = make_frame(seed);
    function_mode = up ? 2'b10 : 2'b01;
    in_valid      = 1'b1;
    step();
    in_valid      = 1'b0;
    function_mode = up ? 2'b01 : 2'b11;
  endtask

  task automatic chk_beat(input string tag, input int i, input logic [7:0] seed, input int r, input logic e);
    chk(tag, q[i].d, exp_row(seed, r));
    chk(tag, RW'({q[i].row, q[i].sop, q[i].eop}), RW'({4'(r), r == 0, e}));
  endtask

  task automatic wait_eop(input string tag);
    int k = 0;
    while (!oif.out_eop && k < 40) begin step(); k++; end
    if (k >= 40) chk(tag, RW'(oif.out_eop), RW'(1));
  endtask

  initial begin
    logic [RW-1:0] pd;
    logic [3:0]    prow;
    logic          pv, pr;
    int            cnt;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; function_mode = 2'b00; oif.out_ready = 1'b0;
    #1;
    chk("rst_meta", meta(oif.out_valid, oif.out_row, oif.out_sop, oif.out_eop), meta(0, 0, 0, 0));
    chk("rst_stat", RW'({busy, overflow, frames_dropped}), RW'(0));
    #20; @(negedge clk); rst = 1'b0;
    step();

    // upsample frame, consumer always ready
    oif.out_ready = 1'b1;
    send(8'h01, 1'b1);
    chk("up_lat", RW'({oif.out_valid, busy}), RW'(2'b01));
    for (int r = 0; r < 14; r++) begin
      step();
      chk("up_data", oif.out_data, exp_row(8'h01, r));
      chk("up_meta", meta(oif.out_valid, oif.out_row, oif.out_sop, oif.out_eop),
          meta(1, 4'(r), r == 0, r == 13));
    end
    step();
    chk("up_done", RW'({oif.out_valid, busy}), RW'(0));

    // downsample frame: rows 0..3 only
    q.delete();
    send(8'h02, 1'b0);
    repeat (8) step();
    chk("dn_count", RW'(q.size()), RW'(4));
    for (int i = 0; i < q.size() && i < 4; i++) chk_beat("dn_beat", i, 8'h02, i, i == 3);

    // random backpressure over an upsample + downsample pair
    q.delete();
    oif.out_ready = 1'b0;
    send(8'h03, 1'b1);
    send(8'h04, 1'b0);
    pv = 1'b0; pr = 1'b0; pd = '0; prow = '0; cnt = 0;
    while (cnt < 600 && (busy || oif.out_valid)) begin
      if (pv && !pr) begin
        chk("bp_hold_data", oif.out_data, pd);
        chk("bp_hold_row", RW'(oif.out_row), RW'(prow));
      end
      pd = oif.out_data; prow = oif.out_row; pv = oif.out_valid;
      oif.out_ready = 1'($urandom_range(0, 1));
      pr = oif.out_ready;
      step();
      cnt++;
    end
    chk("bp_drained", RW'(cnt < 600), RW'(1));
    chk("bp_count", RW'(q.size()), RW'(18));
    for (int i = 0; i < q.size() && i < 18; i++)
      if (i < 14) chk_beat("bp_beat", i, 8'h03, i, i == 13);
      else        chk_beat("bp_beat", i, 8'h04, i - 14, i == 17);

    // overflow: third frame dropped, first two emitted back-to-back
    q.delete();
    oif.out_ready = 1'b0;
    send(8'h05, 1'b1);
    send(8'h06, 1'b1);
    send(8'h07, 1'b1);
    chk("ov_flag", RW'({overflow, frames_dropped}), RW'({1'b1, 8'd1}));
    oif.out_ready = 1'b1;
    cnt = 0;
    while (oif.out_valid && cnt < 100) begin step(); cnt++; end
    chk("ov_run_len", RW'(cnt), RW'(28));
    chk("ov_count", RW'(q.size()), RW'(28));
    if (q.size() == 28) begin
      chk_beat("ov_f1_first", 0, 8'h05, 0, 1'b0);
      chk_beat("ov_f1_last", 13, 8'h05, 13, 1'b1);
      chk_beat("ov_f2_first", 14, 8'h06, 0, 1'b0);
      chk_beat("ov_f2_last", 27, 8'h06, 13, 1'b1);
    end

    // saturation of the drop counter, then asynchronous reset mid-frame
    oif.out_ready = 1'b0;
    send(8'h20, 1'b1);
    send(8'h21, 1'b1);
    in_valid = 1'b1;
    repeat (300) step();
    in_valid = 1'b0;
    chk("sat_cnt", RW'(frames_dropped), RW'(8'd255));
    oif.out_ready = 1'b1;
    repeat (3) step();
    chk("sat_mid", meta(oif.out_valid, oif.out_row, oif.out_sop, oif.out_eop), meta(1, 3, 0, 0));
    #2; rst = 1'b1; #1;
    chk("ar_meta", meta(oif.out_valid, oif.out_row, oif.out_sop, oif.out_eop), meta(0, 0, 0, 0));
    chk("ar_data", oif.out_data, '0);
    chk("ar_stat", RW'({busy, overflow, frames_dropped}), RW'(0));
    @(negedge clk); rst = 1'b0;
    step();
    chk("ar_post", RW'({busy, overflow, oif.out_valid}), RW'(0));

    // eop accept coinciding with a capture: same buffer -> drop, other buffer -> no bubble
    send(8'h08, 1'b0);
    send(8'h09, 1'b0);
    wait_eop("sim_eop_a");
    chk("sim_eop_a_data", oif.out_data, exp_row(8'h08, 3));
    send(8'h0A, 1'b0);
    chk("sim_drop", RW'(frames_dropped), RW'(1));
    chk("sim_b_meta", meta(oif.out_valid, oif.out_row, oif.out_sop, oif.out_eop), meta(1, 0, 1, 0));
    chk("sim_b_data", oif.out_data, exp_row(8'h09, 0));
    wait_eop("sim_eop_b");
    send(8'h0B, 1'b1);
    chk("sim_d_meta", meta(oif.out_valid, oif.out_row, oif.out_sop, oif.out_eop), meta(1, 0, 1, 0));
    chk("sim_d_data", oif.out_data, exp_row(8'h0B, 0));
    chk("sim_d_nodrop", RW'(frames_dropped), RW'(1));
    cnt = 0;
    while (busy && cnt < 40) begin step(); cnt++; end
    chk("sim_idle", RW'({busy, oif.out_valid}), RW'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
